// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared types and constants for the PLL lock sequencer
package pll_seq_pkg;
  typedef enum logic [1:0] {HOLD, WAIT_LOCK, RUN, FAULT} pll_seq_state_t;
  localparam int RELOCK_CNT_W = 8;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: 1-bit two-flop synchronizer, resets to 0
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta_q, sync_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end
  assign q = sync_q;
endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: holds the PLL in reset, qualifies LOCK, releases the PLL-clocked core, retries and faults
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RESET_HOLD_CYCLES   = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 4096,
  parameter int LOCK_STABLE_CYCLES  = 64,
  parameter int MAX_RETRIES         = 3,
  parameter int CNT_W               = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pll_lock,
  input  logic                    relock_req,
  output logic                    pll_resetb,
  output logic                    pll_bypass,
  output logic                    core_rst_n,
  output logic                    locked,
  output logic                    fault,
  output logic [RELOCK_CNT_W-1:0] relock_count
);
  localparam int RETRY_W = $clog2(MAX_RETRIES + 1);
  localparam longint CNT_SPAN = longint'(1) << CNT_W;
  if (RESET_HOLD_CYCLES < 1 || LOCK_TIMEOUT_CYCLES < 1 || LOCK_STABLE_CYCLES < 1 || MAX_RETRIES < 1 ||
      longint'(RESET_HOLD_CYCLES) > CNT_SPAN || longint'(LOCK_TIMEOUT_CYCLES) > CNT_SPAN ||
      longint'(LOCK_STABLE_CYCLES) > CNT_SPAN) begin : g_param_check
    $fatal(1, "pll_lock_sequencer: cycle parameters must be >= 1 and fit in CNT_W");
  end
  localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);
  pll_seq_state_t          state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d, scnt_q, scnt_d;
  logic [RETRY_W-1:0]      retries_q, retries_d, retries_inc;
  logic [RELOCK_CNT_W-1:0] relock_cnt_q, relock_cnt_d;
  logic                    resetb_q, resetb_d, run_q, run_d, fault_q, fault_d;
  logic                    lock_s;
  sync_2ff u_lock_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (pll_lock),
    .q    (lock_s)
  );
  // Outputs are registered from the next state so they change on the same edge as state_q.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    scnt_d       = '0;
    retries_d    = retries_q;
    relock_cnt_d = relock_cnt_q;
    retries_inc  = retries_q + RETRY_W'(1);
    case (state_q)
      HOLD: begin
        cnt_d   = (cnt_q == HOLD_LAST) ? '0 : cnt_q + CNT_W'(1);
        state_d = (cnt_q == HOLD_LAST) ? WAIT_LOCK : HOLD;
      end
      WAIT_LOCK: begin
        cnt_d  = cnt_q + CNT_W'(1);
        scnt_d = lock_s ? scnt_q + CNT_W'(1) : '0;
        if (lock_s && scnt_q == STABLE_LAST) begin
          state_d   = RUN;
          cnt_d     = '0;
          scnt_d    = '0;
          retries_d = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          retries_d = retries_inc;
          cnt_d     = '0;
          scnt_d    = '0;
          state_d   = (retries_inc == RETRY_LIMIT) ? FAULT : HOLD;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d      = HOLD;
          cnt_d        = '0;
          relock_cnt_d = (&relock_cnt_q) ? relock_cnt_q : relock_cnt_q + RELOCK_CNT_W'(1);
        end
      end
      default: state_d = FAULT;
    endcase
    if (relock_req) begin
      state_d      = HOLD;
      cnt_d        = '0;
      scnt_d       = '0;
      retries_d    = '0;
      relock_cnt_d = relock_cnt_q;
    end
    resetb_d = (state_d == WAIT_LOCK) || (state_d == RUN);
    run_d    = state_d == RUN;
    fault_d  = state_d == FAULT;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= HOLD;
      cnt_q        <= '0;
      scnt_q       <= '0;
      retries_q    <= '0;
      relock_cnt_q <= '0;
      resetb_q     <= 1'b0;
      run_q        <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      scnt_q       <= scnt_d;
      retries_q    <= retries_d;
      relock_cnt_q <= relock_cnt_d;
      resetb_q     <= resetb_d;
      run_q        <= run_d;
      fault_q      <= fault_d;
    end
  end
  assign pll_resetb   = resetb_q;
  assign pll_bypass   = fault_q;
  assign core_rst_n   = run_q;
  assign locked       = run_q;
  assign fault        = fault_q;
  assign relock_count = relock_cnt_q;
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: self-checking bench, lock-timing vector table plus hand-written corner sequences
module tb_pll_lock_sequencer;
  import pll_seq_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, pll_lock = 1'b0, relock_req = 1'b0;
  logic pll_resetb, pll_bypass, core_rst_n, locked, fault;
  logic [RELOCK_CNT_W-1:0] relock_count;
  int n_checks = 0, n_errors = 0;
  typedef struct {
    string name;
    int    d;
    int    g;
    int    rise;
  } vec_t;
  typedef struct {
    string name;
    int    val;
  } exp_t;
  exp_t sb[$];
  vec_t vecs[6];
  always #5 clk = ~clk;
  pll_lock_sequencer #(.LOCK_TIMEOUT_CYCLES(100)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pll_lock    (pll_lock),
    .relock_req  (relock_req),
    .pll_resetb  (pll_resetb),
    .pll_bypass  (pll_bypass),
    .core_rst_n  (core_rst_n),
    .locked      (locked),
    .fault       (fault),
    .relock_count(relock_count)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  task automatic push(input string name, input int val);
    sb.push_back('{name, val});
  endtask
  task automatic pop_chk(input logic [31:0] act);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_empty: got %0d, expected a queued value", act);
    end else begin
      e = sb.pop_front();
      chk(e.name, act, e.val);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic outs_zero(input string name);
    chk({name, "_outs"}, {27'd0, pll_resetb, pll_bypass, core_rst_n, locked, fault}, 0);
    chk({name, "_relock_count"}, relock_count, 0);
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    relock_req = 1'b0;
    pll_lock = 1'b0;
    tick;
    tick;
    outs_zero("reset");
    rst_n = 1'b1;
  endtask
  task automatic wait_resetb_rise(output int n);
    n = 0;
    while (!pll_resetb && n < 1000) begin
      n++;
      tick;
    end
  endtask
  task automatic wait_locked(input logic v, input int lim, output int n);
    n = 0;
    while (locked !== v && n < lim) begin
      tick;
      n++;
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, t, rises, timeouts;
    logic prev, saw_core;
    vecs[0] = '{"nominal", 10, -1, 76};
    vecs[1] = '{"lock_at_release", 0, -1, 66};
    vecs[2] = '{"chatter_30", 0, 30, 97};
    vecs[3] = '{"chatter_20", 5, 20, 87};
    vecs[4] = '{"stable_on_timeout", 34, -1, 100};
    vecs[5] = '{"timeout_then_retry", 35, -1, 180};
    #2;
    foreach (vecs[i]) begin
      do_reset;
      wait_resetb_rise(n);
      chk({vecs[i].name, "_hold"}, n, 16);
      push({vecs[i].name, "_rise"}, vecs[i].rise);
      t = 0;
      while (!core_rst_n && t < 400) begin
        pll_lock = (t >= vecs[i].d) && (t != vecs[i].g);
        tick;
        t++;
      end
      pop_chk(t);
      chk({vecs[i].name, "_locked"}, locked, 1);
      chk({vecs[i].name, "_relock_count"}, relock_count, 0);
      chk({vecs[i].name, "_fault"}, fault, 0);
    end
    do_reset;
    wait_resetb_rise(n);
    chk("fault_hold", n, 16);
    t = 0;
    rises = 1;
    prev = 1'b1;
    saw_core = 1'b0;
    while (!fault && t < 1000) begin
      tick;
      t++;
      if (pll_resetb && !prev) rises++;
      prev = pll_resetb;
      if (core_rst_n) saw_core = 1'b1;
    end
    chk("fault_cycle", t, 332);
    chk("fault_attempts", rises, 3);
    chk("fault_core_held", saw_core, 0);
    chk("fault_outs", {pll_resetb, pll_bypass, core_rst_n, locked}, 4'b0100);
    repeat (50) tick;
    chk("fault_sticky", {pll_bypass, fault}, 2'b11);
    pll_lock = 1'b1;
    relock_req = 1'b1;
    tick;
    relock_req = 1'b0;
    chk("relock_clears_fault", {pll_bypass, fault, pll_resetb}, 0);
    push("relock_lock_cycles", 80);
    wait_locked(1'b1, 400, n);
    pop_chk(n);
    chk("relock_fault", fault, 0);
    chk("relock_count_kept", relock_count, 0);
    pll_lock = 1'b0;
    tick;
    pll_lock = 1'b1;
    n = 1;
    while (core_rst_n && n < 20) begin
      tick;
      n++;
    end
    chk("loss_latency", n, 3);
    chk("loss_relock_count", relock_count, 1);
    chk("loss_resetb", pll_resetb, 0);
    push("loss_relock_cycles", 80);
    wait_locked(1'b1, 400, n);
    pop_chk(n);
    chk("loss_no_fault", fault, 0);
    timeouts = 0;
    for (int i = 2; i <= 300; i++) begin
      pll_lock = 1'b0;
      tick;
      pll_lock = 1'b1;
      wait_locked(1'b0, 20, n);
      if (n >= 20) timeouts++;
      wait_locked(1'b1, 400, n);
      if (n >= 400) timeouts++;
      if (i == 2) chk("loss_relock_count_2", relock_count, 2);
    end
    chk("loss_loop_timeouts", timeouts, 0);
    chk("relock_count_saturated", relock_count, 255);
    chk("loss_loop_locked", {locked, fault}, 2'b10);
    pll_lock = 1'b1;
    rst_n = 1'b0;
    tick;
    outs_zero("rst_in_run");
    rst_n = 1'b1;
    wait_resetb_rise(n);
    chk("rst_in_run_hold", n, 16);
    repeat (20) tick;
    rst_n = 1'b0;
    tick;
    outs_zero("rst_in_wait");
    rst_n = 1'b1;
    wait_resetb_rise(n);
    chk("rst_in_wait_hold", n, 16);
    wait_locked(1'b1, 400, n);
    chk("rst_in_wait_relock", n, 64);
    do_reset;
    wait_resetb_rise(n);
    pll_lock = 1'b1;
    repeat (65) tick;
    relock_req = 1'b1;
    tick;
    relock_req = 1'b0;
    chk("req_vs_stable_outs", {pll_resetb, core_rst_n, locked}, 0);
    wait_locked(1'b1, 400, n);
    chk("req_vs_stable_relock", n, 80);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
